alien_bomb_controller: RTL and testbench



---
 rtl/alien_bomb_controller.sv | 208 ++++++++++++++++++++
 tb/tb_alien_bomb_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_bomb_controller.sv
// Alien bomb pool: LFSR-picked spawning, per-frame fall, player collision,
// lives tracking and bomb pixel flag for the color mapper.
module alien_bomb_controller #(
  parameter int unsigned NUM_BOMBS     = 3,
  parameter logic [9:0]  BOMB_SPEED    = 10'd4,
  parameter logic [7:0]  FIRE_PERIOD   = 8'd30,
  parameter logic [9:0]  SPAWN_OFFSET  = 10'd12,
  parameter logic [9:0]  HIT_THRESHOLD = 10'd16,
  parameter logic [1:0]  INIT_LIVES    = 2'd3,
  parameter logic [9:0]  BOMB_HALF_W   = 10'd2,
  parameter logic [9:0]  BOMB_HALF_H   = 10'd4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_clk,
  input  logic                        enable,
  input  logic [9:0]                  alien_alive,
  input  logic [9:0][9:0]             alien_x_pos,
  input  logic [9:0][9:0]             alien_y_pos,
  input  logic [9:0]                  player_x_pos,
  input  logic [9:0]                  player_y_pos,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  output logic [NUM_BOMBS-1:0][9:0]   bomb_x_pos,
  output logic [NUM_BOMBS-1:0][9:0]   bomb_y_pos,
  output logic [NUM_BOMBS-1:0]        bomb_active,
  output logic                        is_bomb,
  output logic                        is_player_hit,
  output logic [1:0]                  lives,
  output logic                        is_dead
);

  localparam int unsigned NUM_ALIENS = 10;
  localparam int unsigned POS_W      = 10;
  localparam int unsigned LFSR_W     = 8;
  localparam int unsigned IDX_W      = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [POS_W:0]    BOTTOM_Y  = 11'd479;

  // Unsigned distance between two screen coordinates
  function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                input logic [POS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic                            frame_clk_d;
  logic                            frame_tick;
  logic [LFSR_W-1:0]               lfsr;
  logic [LFSR_W-1:0]               lfsr_nxt;
  logic [7:0]                      cooldown;
  logic [7:0]                      cooldown_nxt;
  logic [NUM_BOMBS-1:0]            active_nxt;
  logic [NUM_BOMBS-1:0][POS_W-1:0] bx_nxt;
  logic [NUM_BOMBS-1:0][POS_W-1:0] by_nxt;
  logic [1:0]                      lives_nxt;
  logic                            dead_nxt;
  logic                            hit_nxt;
  logic                            any_hit;

  logic [NUM_BOMBS-1:0]            slot_hit;
  logic [NUM_BOMBS-1:0]            slot_bottom;
  logic [NUM_BOMBS-1:0]            free_oh;
  logic [IDX_W-1:0]                start_idx;
  logic [IDX_W:0]                  cand_wide;
  logic [IDX_W-1:0]                cand;
  logic                            src_found;
  logic [POS_W-1:0]                src_x;
  logic [POS_W-1:0]                src_y;

  assign frame_tick = frame_clk & ~frame_clk_d;

  // Frame edge detector runs every Clk, regardless of enable
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) frame_clk_d <= 1'b0;
    else       frame_clk_d <= frame_clk;
  end

  // Game state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr          <= LFSR_SEED;
      cooldown      <= FIRE_PERIOD;
      bomb_active   <= '0;
      bomb_x_pos    <= '0;
      bomb_y_pos    <= '0;
      lives         <= INIT_LIVES;
      is_dead       <= (INIT_LIVES == 2'd0);
      is_player_hit <= 1'b0;
    end else begin
      lfsr          <= lfsr_nxt;
      cooldown      <= cooldown_nxt;
      bomb_active   <= active_nxt;
      bomb_x_pos    <= bx_nxt;
      bomb_y_pos    <= by_nxt;
      lives         <= lives_nxt;
      is_dead       <= dead_nxt;
      is_player_hit <= hit_nxt;
    end
  end

  // Per-slot collision and bottom-exit flags from the pre-tick positions
  always_comb begin
    slot_hit    = '0;
    slot_bottom = '0;
    for (int unsigned j = 0; j < NUM_BOMBS; j++) begin
      slot_hit[j] = (abs_diff(bomb_x_pos[j], player_x_pos) < HIT_THRESHOLD) &&
                    (abs_diff(bomb_y_pos[j], player_y_pos) < HIT_THRESHOLD);
      slot_bottom[j] = (({1'b0, bomb_y_pos[j]} + {1'b0, BOMB_SPEED}) > BOTTOM_Y);
    end
  end

  // Lowest slot that is free before the tick (one-hot, zero when pool is full)
  assign free_oh = ~bomb_active & (bomb_active + NUM_BOMBS'(1));

  // Circular search for the first living alien starting at the LFSR index
  always_comb begin
    start_idx = (lfsr[3:0] >= 4'd10) ? (lfsr[3:0] - 4'd10) : lfsr[3:0];
    cand_wide = '0;
    cand      = '0;
    src_found = 1'b0;
    src_x     = '0;
    src_y     = '0;
    for (int unsigned k = 0; k < NUM_ALIENS; k++) begin
      cand_wide = 5'(start_idx) + 5'(k);
      if (cand_wide >= 5'd10) cand_wide = cand_wide - 5'd10;
      cand = 4'(cand_wide);
      if (!src_found && alien_alive[cand]) begin
        src_found = 1'b1;
        src_x     = alien_x_pos[cand];
        src_y     = alien_y_pos[cand] + SPAWN_OFFSET;
      end
    end
  end

  // Per-tick update: move/clear bombs, count lives, cooldown and spawning
  always_comb begin
    lfsr_nxt     = lfsr;
    cooldown_nxt = cooldown;
    active_nxt   = bomb_active;
    bx_nxt       = bomb_x_pos;
    by_nxt       = bomb_y_pos;
    lives_nxt    = lives;
    dead_nxt     = is_dead;
    hit_nxt      = 1'b0;
    any_hit      = 1'b0;

    if (frame_tick && enable) begin
      lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      if (is_dead) begin
        active_nxt = '0;
        bx_nxt     = '0;
        by_nxt     = '0;
      end else begin
        for (int unsigned j = 0; j < NUM_BOMBS; j++) begin
          if (bomb_active[j]) begin
            if (slot_hit[j]) begin
              active_nxt[j] = 1'b0;
              bx_nxt[j]     = '0;
              by_nxt[j]     = '0;
              any_hit       = 1'b1;
            end else if (slot_bottom[j]) begin
              active_nxt[j] = 1'b0;
              bx_nxt[j]     = '0;
              by_nxt[j]     = '0;
            end else begin
              by_nxt[j] = bomb_y_pos[j] + BOMB_SPEED;
            end
          end
        end

        if (any_hit) begin
          lives_nxt = (lives == 2'd0) ? 2'd0 : (lives - 2'd1);
          hit_nxt   = 1'b1;
        end

        // Failed attempts leave the counter at zero so the next tick retries
        if (cooldown != 8'd0) begin
          cooldown_nxt = cooldown - 8'd1;
        end else if (src_found && (free_oh != '0)) begin
          for (int unsigned j = 0; j < NUM_BOMBS; j++) begin
            if (free_oh[j]) begin
              active_nxt[j] = 1'b1;
              bx_nxt[j]     = src_x;
              by_nxt[j]     = src_y;
            end
          end
          cooldown_nxt = FIRE_PERIOD;
        end
      end

      dead_nxt = (lives_nxt == 2'd0);
    end
  end

  // Pixel-in-bomb test against every active slot
  always_comb begin
    is_bomb = 1'b0;
    for (int unsigned j = 0; j < NUM_BOMBS; j++) begin
      if (bomb_active[j] &&
          (abs_diff(DrawX, bomb_x_pos[j]) <= BOMB_HALF_W) &&
          (abs_diff(DrawY, bomb_y_pos[j]) <= BOMB_HALF_H)) begin
        is_bomb = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alien_bomb_controller.sv
// Directed bench for alien_bomb_controller with FIRE_PERIOD = 2.
module tb_alien_bomb_controller;

  localparam int unsigned NB = 3;

  logic                 Clk;
  logic                 Reset;
  logic                 frame_clk;
  logic                 enable;
  logic [9:0]           alien_alive;
  logic [9:0][9:0]      alien_x_pos;
  logic [9:0][9:0]      alien_y_pos;
  logic [9:0]           player_x_pos;
  logic [9:0]           player_y_pos;
  logic [9:0]           DrawX;
  logic [9:0]           DrawY;
  logic [NB-1:0][9:0]   bomb_x_pos;
  logic [NB-1:0][9:0]   bomb_y_pos;
  logic [NB-1:0]        bomb_active;
  logic                 is_bomb;
  logic                 is_player_hit;
  logic [1:0]           lives;
  logic                 is_dead;

  int errors = 0;
  int checks = 0;
  logic [NB-1:0] seen_active;

  alien_bomb_controller #(.NUM_BOMBS(NB), .FIRE_PERIOD(8'd2)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
    .alien_alive(alien_alive), .alien_x_pos(alien_x_pos), .alien_y_pos(alien_y_pos),
    .player_x_pos(player_x_pos), .player_y_pos(player_y_pos),
    .DrawX(DrawX), .DrawY(DrawY),
    .bomb_x_pos(bomb_x_pos), .bomb_y_pos(bomb_y_pos), .bomb_active(bomb_active),
    .is_bomb(is_bomb), .is_player_hit(is_player_hit), .lives(lives), .is_dead(is_dead)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One VGA_VS rising edge seen by exactly one Clk edge; returns at a negedge
  task automatic tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic set_alien_y(input logic [9:0] y);
    for (int i = 0; i < 10; i++) alien_y_pos[i] = y;
  endtask

  task automatic player_far();
    player_x_pos = 10'd50;
    player_y_pos = 10'd100;
  endtask

  initial begin
    Reset       = 1'b0;
    frame_clk   = 1'b0;
    enable      = 1'b1;
    alien_alive = 10'h3FF;
    for (int i = 0; i < 10; i++) alien_x_pos[i] = 10'(220 + 20 * i);
    set_alien_y(10'd20);
    player_far();
    DrawX = 10'd0;
    DrawY = 10'd0;

    // Reset values
    #2 Reset = 1'b1;
    @(negedge Clk);
    check("rst_active", 32'(bomb_active), 32'd0);
    check("rst_x0", 32'(bomb_x_pos[0]), 32'd0);
    check("rst_y2", 32'(bomb_y_pos[2]), 32'd0);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_dead", 32'(is_dead), 32'd0);
    check("rst_hit", 32'(is_player_hit), 32'd0);
    check("rst_bomb", 32'(is_bomb), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // First spawn on tick 3 from alien 5, then fall and second spawn on tick 6
    ticks(2);
    check("p1_none_t2", 32'(bomb_active), 32'd0);
    tick();
    check("p1_active_t3", 32'(bomb_active), 32'd1);
    check("p1_x0_t3", 32'(bomb_x_pos[0]), 32'd320);
    check("p1_y0_t3", 32'(bomb_y_pos[0]), 32'd32);
    tick();
    check("p1_y0_t4", 32'(bomb_y_pos[0]), 32'd36);
    check("p1_active_t4", 32'(bomb_active), 32'd1);
    tick();
    check("p1_y0_t5", 32'(bomb_y_pos[0]), 32'd40);
    tick();
    check("p1_active_t6", 32'(bomb_active), 32'd3);
    check("p1_x1_t6", 32'(bomb_x_pos[1]), 32'd400);
    check("p1_y1_t6", 32'(bomb_y_pos[1]), 32'd32);
    check("p1_y0_t6", 32'(bomb_y_pos[0]), 32'd44);

    // Pixel window around bomb 0 at (320,44) and bomb 1 at (400,32)
    DrawX = 10'd320; DrawY = 10'd44; #1;
    check("draw_center", 32'(is_bomb), 32'd1);
    DrawX = 10'd322; DrawY = 10'd48; #1;
    check("draw_corner", 32'(is_bomb), 32'd1);
    DrawX = 10'd323; #1;
    check("draw_x_out", 32'(is_bomb), 32'd0);
    DrawX = 10'd322; DrawY = 10'd49; #1;
    check("draw_y_out", 32'(is_bomb), 32'd0);
    DrawX = 10'd398; DrawY = 10'd28; #1;
    check("draw_slot1", 32'(is_bomb), 32'd1);
    DrawX = 10'd0; DrawY = 10'd0; #1;

    // Skip dead aliens: start index 5 lands on alien 6; retry while none alive
    alien_alive = 10'b1111000000;
    do_reset();
    ticks(3);
    check("p2_src6_x", 32'(bomb_x_pos[0]), 32'd340);
    check("p2_src6_y", 32'(bomb_y_pos[0]), 32'd32);
    alien_alive = 10'h000;
    ticks(4);
    check("p2_no_alive", 32'(bomb_active), 32'd1);
    alien_alive = 10'h001;
    tick();
    check("p2_retry_active", 32'(bomb_active), 32'd3);
    check("p2_retry_x1", 32'(bomb_x_pos[1]), 32'd220);
    check("p2_retry_y1", 32'(bomb_y_pos[1]), 32'd32);
    check("p2_y0", 32'(bomb_y_pos[0]), 32'd52);

    // Bottom exit from y=476
    set_alien_y(10'd464);
    do_reset();
    ticks(3);
    check("p3_y0_476", 32'(bomb_y_pos[0]), 32'd476);
    tick();
    check("p3_exit_active", 32'(bomb_active), 32'd0);
    check("p3_exit_x0", 32'(bomb_x_pos[0]), 32'd0);
    check("p3_exit_y0", 32'(bomb_y_pos[0]), 32'd0);
    check("p3_exit_lives", 32'(lives), 32'd3);

    // Bottom boundary: 475 moves to 479, then exits
    set_alien_y(10'd463);
    do_reset();
    ticks(4);
    check("p3_y0_479", 32'(bomb_y_pos[0]), 32'd479);
    check("p3_479_active", 32'(bomb_active), 32'd1);
    tick();
    check("p3_483_active", 32'(bomb_active), 32'd0);

    // Hit: threshold edge, single hit pulse, double hit counts once
    alien_alive = 10'h010;
    set_alien_y(10'd428);
    player_x_pos = 10'd316; player_y_pos = 10'd456;
    do_reset();
    ticks(3);
    check("p4_x0", 32'(bomb_x_pos[0]), 32'd300);
    check("p4_y0", 32'(bomb_y_pos[0]), 32'd440);
    tick();
    check("p4_dx16_y0", 32'(bomb_y_pos[0]), 32'd444);
    check("p4_dx16_lives", 32'(lives), 32'd3);
    check("p4_dx16_hit", 32'(is_player_hit), 32'd0);
    player_x_pos = 10'd315; player_y_pos = 10'd459;
    tick();
    check("p4_hit_active", 32'(bomb_active), 32'd0);
    check("p4_hit_x0", 32'(bomb_x_pos[0]), 32'd0);
    check("p4_hit_pulse", 32'(is_player_hit), 32'd1);
    check("p4_hit_lives", 32'(lives), 32'd2);
    check("p4_hit_dead", 32'(is_dead), 32'd0);
    @(negedge Clk);
    check("p4_pulse_end", 32'(is_player_hit), 32'd0);
    player_far();
    ticks(4);
    check("p4_two_active", 32'(bomb_active), 32'd3);
    player_x_pos = 10'd300; player_y_pos = 10'd446;
    tick();
    check("p4_dbl_active", 32'(bomb_active), 32'd0);
    check("p4_dbl_lives", 32'(lives), 32'd1);
    check("p4_dbl_pulse", 32'(is_player_hit), 32'd1);

    // Death: last life lost, slots cleared on the next tick, no more spawns
    player_far();
    ticks(5);
    check("p5_two_active", 32'(bomb_active), 32'd3);
    player_x_pos = 10'd300; player_y_pos = 10'd466;
    tick();
    check("p5_kill_active", 32'(bomb_active), 32'd2);
    check("p5_kill_y1", 32'(bomb_y_pos[1]), 32'd444);
    check("p5_kill_lives", 32'(lives), 32'd0);
    check("p5_kill_dead", 32'(is_dead), 32'd1);
    player_far();
    tick();
    check("p5_clear_active", 32'(bomb_active), 32'd0);
    check("p5_clear_x1", 32'(bomb_x_pos[1]), 32'd0);
    check("p5_clear_y1", 32'(bomb_y_pos[1]), 32'd0);
    seen_active = '0;
    for (int n = 0; n < 100; n++) begin
      tick();
      seen_active = seen_active | bomb_active;
    end
    check("p5_no_spawn", 32'(seen_active), 32'd0);
    check("p5_still_dead", 32'(is_dead), 32'd1);

    // Pool full holds the counter at zero; a freed slot waits one tick
    alien_alive = 10'h001;
    set_alien_y(10'd20);
    do_reset();
    ticks(9);
    check("p6_full_t9", 32'(bomb_active), 32'd7);
    ticks(4);
    check("p6_full_t13", 32'(bomb_active), 32'd7);
    check("p6_y0_t13", 32'(bomb_y_pos[0]), 32'd72);
    player_x_pos = 10'd220; player_y_pos = 10'd80;
    tick();
    check("p6_freed_active", 32'(bomb_active), 32'd6);
    check("p6_freed_lives", 32'(lives), 32'd2);
    player_far();
    tick();
    check("p6_reuse_active", 32'(bomb_active), 32'd7);
    check("p6_reuse_y0", 32'(bomb_y_pos[0]), 32'd32);
    check("p6_reuse_y1", 32'(bomb_y_pos[1]), 32'd68);

    // Asynchronous reset mid-flight
    DrawX = 10'd220; DrawY = 10'd32; #1;
    check("p6_pre_rst_bomb", 32'(is_bomb), 32'd1);
    #1 Reset = 1'b1;
    #1;
    check("p6_arst_active", 32'(bomb_active), 32'd0);
    check("p6_arst_x0", 32'(bomb_x_pos[0]), 32'd0);
    check("p6_arst_y1", 32'(bomb_y_pos[1]), 32'd0);
    check("p6_arst_lives", 32'(lives), 32'd3);
    check("p6_arst_hit", 32'(is_player_hit), 32'd0);
    check("p6_arst_dead", 32'(is_dead), 32'd0);
    check("p6_arst_bomb", 32'(is_bomb), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0;

    // Ticks while disabled are lost
    alien_alive = 10'h020;
    do_reset();
    enable = 1'b0;
    ticks(5);
    check("p7_frozen", 32'(bomb_active), 32'd0);
    enable = 1'b1;
    ticks(2);
    check("p7_enabled_t2", 32'(bomb_active), 32'd0);
    tick();
    check("p7_enabled_t3", 32'(bomb_active), 32'd1);
    check("p7_x0", 32'(bomb_x_pos[0]), 32'd320);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
